// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_pkg
//  Description : Shared CPU definitions for the fetch stage. Holds the reset
//                PC default, the NOP encoding used for bubbles and faulted
//                fetches, and the fetch FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    // HOLD: one bubble cycle after reset release; RUN: normal fetching.
    typedef enum logic [0:0] {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_ifid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ifid_reg
//  Description : IF/ID pipeline register with hold and bubble controls.
//                bubble_i has priority over hold_i and clears every field.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                hold_i            - keep current contents
//                bubble_i          - load an empty slot (all zero)
//                pc_i/inst_i/adel_i- fetch being loaded (valid is implied)
//                id_*_o            - registered IF/ID contents
//  Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        adel_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_adel_o
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] inst_q,  inst_d;
    logic        valid_q, valid_d;
    logic        adel_q,  adel_d;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        adel_d  = adel_q;
        if (bubble_i) begin
            pc_d    = 32'h0000_0000;
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (!hold_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
            adel_d  = adel_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 32'h0000_0000;
            inst_q  <= NOP_WORD;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
        end
    end

    assign id_pc_o    = pc_q;
    assign id_inst_o  = inst_q;
    assign id_valid_o = valid_q;
    assign id_adel_o  = adel_q;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch stage. Owns the PC, next-PC selection,
//                fetch fault detection and the HOLD/RUN fetch FSM, and feeds
//                the IF/ID register. Memory is combinational: the word for
//                inst_addr_o arrives on inst_data_i in the same cycle.
//  Ports       : clk, rst_n                      - clock, async active-low reset
//                stall_i                         - freeze PC and IF/ID
//                branch_taken_i/branch_target_i  - branch redirect from ID
//                exc_redirect_i/exc_pc_i         - exception/ERET redirect
//                inst_ce_o/inst_addr_o/inst_data_i - instruction memory port
//                id_pc_o/id_inst_o/id_valid_o/id_adel_o - IF/ID contents
//                fetch_cnt_o                     - count of valid IF/ID loads
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MEM_BYTES = 4096
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        exc_redirect_i,
    input  logic [31:0] exc_pc_i,
    output logic        inst_ce_o,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_data_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_adel_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [31:0] C_MEM_LIMIT = 32'(MEM_BYTES);

    function automatic logic is_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= C_MEM_LIMIT);
    endfunction

    fetch_state_e state_q;
    logic         ce_q;
    logic [31:0]  pc_q,        pc_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;

    logic         run;
    logic         fault;
    logic         load;
    logic         bubble;
    logic         hold;
    logic [31:0]  fetch_word;

    always_comb begin
        run        = (state_q == ST_RUN);
        fault      = is_fault(pc_q);
        // exc_redirect_i wins over stall_i; HOLD always inserts a bubble.
        bubble     = !run || exc_redirect_i;
        hold       = run && stall_i && !exc_redirect_i;
        load       = run && !stall_i && !exc_redirect_i;
        fetch_word = fault ? NOP_WORD : inst_data_i;

        pc_d = pc_q;
        if (run) begin
            if (exc_redirect_i) begin
                pc_d = exc_pc_i;
            end else if (!stall_i) begin
                // Branch taken: the delay slot at pc_q is loaded this cycle,
                // the target is fetched on the next one.
                pc_d = branch_taken_i ? branch_target_i : (pc_q + 32'd4);
            end
        end

        fetch_cnt_d = load ? (fetch_cnt_q + 32'd1) : fetch_cnt_q;
    end

    // Fetch FSM. HOLD lasts exactly one edge after reset release; RUN is
    // terminal. The chip enable is registered from the next PC so that it
    // tracks the fault status of whatever PC is current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            ce_q    <= 1'b0;
        end else begin
            state_q <= ST_RUN;
            ce_q    <= !is_fault(pc_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (hold),
        .bubble_i   (bubble),
        .pc_i       (pc_q),
        .inst_i     (fetch_word),
        .adel_i     (fault),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o),
        .id_adel_o  (id_adel_o)
    );

    assign inst_ce_o   = ce_q;
    assign inst_addr_o = pc_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Self-checking bench for inst_fetch. A driver issues one
//                fetch-cycle of stimulus per clock and pushes the IF/ID
//                contents the reference model predicts; a monitor pops and
//                compares after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MEMB   = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        exc_redirect_i = 1'b0;
    logic [31:0] exc_pc_i = '0;
    logic        inst_ce_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_adel_o;
    logic [31:0] fetch_cnt_o;

    inst_fetch #(.RESET_PC(RST_PC), .MEM_BYTES(MEMB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .exc_redirect_i  (exc_redirect_i),
        .exc_pc_i        (exc_pc_i),
        .inst_ce_o       (inst_ce_o),
        .inst_addr_o     (inst_addr_o),
        .inst_data_i     (inst_data_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .id_adel_o       (id_adel_o),
        .fetch_cnt_o     (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory.
    assign inst_data_i = inst_addr_o ^ 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        adel;
        logic [31:0] cnt;
    } ifid_t;

    ifid_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    ifid_t       m_id;

    function automatic bit m_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= MEMB);
    endfunction

    function automatic ifid_t empty_slot();
        ifid_t e;
        e.pc = 0; e.inst = 0; e.valid = 0; e.adel = 0; e.cnt = 0;
        return e;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_pc  = RST_PC;
        m_cnt = 0;
        m_id  = empty_slot();
    endtask

    // One clock of stimulus: drive at the falling edge, check the memory
    // port for the current PC, then predict what IF/ID holds after the edge.
    task automatic step(input bit st, input bit br, input logic [31:0] tgt,
                        input bit ex, input logic [31:0] epc);
        @(negedge clk);
        stall_i         = st;
        branch_taken_i  = br;
        branch_target_i = tgt;
        exc_redirect_i  = ex;
        exc_pc_i        = epc;
        chk("inst_addr", inst_addr_o, m_pc);
        chk("inst_ce", {31'b0, inst_ce_o}, {31'b0, (m_run && !m_fault(m_pc))});
        if (!m_run) begin
            m_id  = empty_slot();
            m_run = 1;
        end else if (ex) begin
            m_id = empty_slot();
            m_pc = epc;
        end else if (!st) begin
            m_id.pc    = m_pc;
            m_id.valid = 1;
            m_id.adel  = m_fault(m_pc);
            m_id.inst  = m_fault(m_pc) ? 32'h0 : (m_pc ^ 32'hA5A5_0000);
            m_cnt      = m_cnt + 1;
            m_pc       = br ? tgt : m_pc + 4;
        end
        m_id.cnt = m_cnt;
        exp_q.push_back(m_id);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        stall_i = 0; branch_taken_i = 0; exc_redirect_i = 0;
        #1;
        chk("rst id_pc", id_pc_o, 32'h0);
        chk("rst id_inst", id_inst_o, 32'h0);
        chk("rst id_valid", {31'b0, id_valid_o}, 32'h0);
        chk("rst id_adel", {31'b0, id_adel_o}, 32'h0);
        chk("rst fetch_cnt", fetch_cnt_o, 32'h0);
        chk("rst inst_ce", {31'b0, inst_ce_o}, 32'h0);
        chk("rst inst_addr", inst_addr_o, RST_PC);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      return 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
        else if (r == 1) return 32'(MEMB + $urandom_range(0, 255) * 4);
        else             return 32'($urandom_range(0, 1023) * 4);
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            ifid_t e;
            e = exp_q.pop_front();
            chk("id_pc", id_pc_o, e.pc);
            chk("id_inst", id_inst_o, e.inst);
            chk("id_valid", {31'b0, id_valid_o}, {31'b0, e.valid});
            chk("id_adel", {31'b0, id_adel_o}, {31'b0, e.adel});
            chk("fetch_cnt", fetch_cnt_o, e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        do_reset();

        step(0, 0, 0, 0, 0);                 // HOLD cycle, ce=0, bubble
        idle(3);                             // loads 0x0, 0x4, 0x8; cnt=3
        step(0, 1, 32'h40, 0, 0);            // delay slot 0x0C
        idle(1);                             // 0x40
        step(0, 1, 32'h10, 0, 0);            // delay slot 0x44
        idle(1);                             // 0x10 in ID
        step(1, 0, 0, 0, 0);                 // three stall cycles
        step(1, 1, 32'h300, 0, 0);           // branch ignored under stall
        step(1, 0, 0, 0, 0);
        idle(1);                             // 0x14
        step(1, 0, 0, 1, 32'h180);           // exc overrides stall -> bubble
        idle(1);                             // 0x180
        step(0, 1, 32'h42, 0, 0);            // delay slot 0x184
        step(0, 1, 32'h1000, 0, 0);          // 0x42 faults, loaded with adel
        step(0, 1, 32'h20, 0, 0);            // 0x1000 faults
        idle(1);                             // 0x20, PC now 0x24
        do_reset();
        idle(4);                             // HOLD then 0x0, 0x4, 0x8

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rand_addr(),
                     $urandom_range(0, 19) == 0, rand_addr());
            end
        end

        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_inst_fetch
`default_nettype wire
